// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/retire sequencer for a fixed-latency, non-stallable
// 32x32 unsigned multiplier. It implements RV32M MUL/MULH/MULHSU/MULHU.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   flush_i              kills all in-flight and queued operations
//   req_*                request handshake: op, rs1, rs2, tag
//   mul_x_o, mul_y_o     registered operand magnitudes to the multiplier
//   mul_result_i         64-bit unsigned product, MUL_LATENCY edges later
//   resp_*               response handshake: data, tag (FIFO head)
//   busy_o               any operation in flight or queued
module mul_issue_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int RESP_DEPTH  = 8,
    parameter int TAG_W       = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [31:0]      req_rs1_i,
    input  logic [31:0]      req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [31:0]      mul_x_o,
    output logic [31:0]      mul_y_o,
    input  logic [63:0]      mul_result_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);
    localparam int STAGES = MUL_LATENCY - 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic             hi_sel;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } trk_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } resp_t;

    // Tracking pipeline mirrors the multiplier stages one-for-one.
    logic [STAGES:0]       vld_pipe;
    trk_t [STAGES:0]       trk_pipe;

    resp_t                 mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    // Credits: operations in flight plus FIFO occupancy.
    logic [CNT_W-1:0]      cnt;

    logic                  accept, push, pop;
    logic                  s1, s2, neg1, neg2;
    logic [31:0]           x_mag, y_mag;
    trk_t                  trk_in;
    trk_t                  trk_out;
    logic [63:0]           prod;
    resp_t                 push_ent;

    // Issue side: signed operands are turned into magnitudes; the sign of the
    // product is carried alongside in the tracking pipe. MUL stays unsigned
    // since its low half does not depend on signedness.
    always_comb begin
        s1     = (req_op_i == 2'b01) || (req_op_i == 2'b10);
        s2     = (req_op_i == 2'b01);
        neg1   = s1 & req_rs1_i[31];
        neg2   = s2 & req_rs2_i[31];
        x_mag  = neg1 ? (32'd0 - req_rs1_i) : req_rs1_i;
        y_mag  = neg2 ? (32'd0 - req_rs2_i) : req_rs2_i;
        trk_in = '{hi_sel: (req_op_i != 2'b00), neg: neg1 ^ neg2, tag: req_tag_i};
    end

    // Credit gate is purely registered state plus reset/flush, so a FIFO pop
    // cannot ripple into req_ready_o in the same cycle.
    assign req_ready_o = rst_ni & ~flush_i & (cnt < CNT_W'(RESP_DEPTH));
    assign accept      = req_valid_i & req_ready_o;

    // Retire side: sign-correct the product and pick the half.
    always_comb begin
        trk_out       = trk_pipe[STAGES];
        prod          = trk_out.neg ? (~mul_result_i + 64'd1) : mul_result_i;
        push_ent.data = trk_out.hi_sel ? prod[63:32] : prod[31:0];
        push_ent.tag  = trk_out.tag;
    end

    assign push         = vld_pipe[STAGES];
    assign resp_valid_o = (fifo_cnt != '0);
    assign pop          = resp_valid_o & resp_ready_i;
    assign resp_data_o  = resp_valid_o ? mem[rd_ptr].data : '0;
    assign resp_tag_o   = resp_valid_o ? mem[rd_ptr].tag  : '0;
    assign busy_o       = (cnt != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            vld_pipe <= '0;
            mul_x_o  <= '0;
            mul_y_o  <= '0;
            cnt      <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            vld_pipe[0] <= accept;
            for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            // Idle cycles drive zero operands so the multiplier sees no stale data.
            mul_x_o  <= accept ? x_mag : 32'd0;
            mul_y_o  <= accept ? y_mag : 32'd0;
            cnt      <= cnt + CNT_W'(accept) - CNT_W'(pop);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Datapath storage carries no reset; validity lives in vld_pipe/fifo_cnt.
    always_ff @(posedge clk_i) begin
        trk_pipe[0] <= trk_in;
        for (int i = 1; i <= STAGES; i++) trk_pipe[i] <= trk_pipe[i-1];
        if (push && rst_ni && !flush_i) mem[wr_ptr] <= push_ent;
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a four-negedge-stage multiplier model drives
// mul_result_i; a queue-based reference model predicts every handshake.
module tb_mul_issue_ctrl;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int TW    = 5;

    logic          clk = 1'b0;
    logic          rst_ni, flush_i, req_valid_i, resp_ready_i;
    logic          req_ready_o, resp_valid_o, busy_o;
    logic [1:0]    req_op_i;
    logic [31:0]   req_rs1_i, req_rs2_i, mul_x_o, mul_y_o, resp_data_o;
    logic [TW-1:0] req_tag_i, resp_tag_o;
    logic [63:0]   mul_result_i;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.MUL_LATENCY(LAT), .RESP_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_tag_i(req_tag_i),
        .mul_x_o(mul_x_o), .mul_y_o(mul_y_o), .mul_result_i(mul_result_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .busy_o(busy_o)
    );

    // Multiplier: four falling-edge stages.
    logic [63:0] mp [4] = '{default: 64'd0};
    always @(negedge clk) begin
        mp[0] <= {32'd0, mul_x_o} * {32'd0, mul_y_o};
        mp[1] <= mp[0];
        mp[2] <= mp[1];
        mp[3] <= mp[2];
    end
    assign mul_result_i = mp[3];

    // Reference model: ordered queue of expected responses, each visible from
    // a given cycle on (handshake cycle + LAT + 1).
    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        int            avail;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_x, exp_y;
    int          cyc, checks, errors, accepts, pops;
    logic        s_ready, s_valid, s_busy;
    logic [31:0] s_data;
    logic [TW-1:0] s_tag;

    function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {{32{a[31] & (op == 2'b01 || op == 2'b10)}}, a};
        eb = {{32{b[31] & (op == 2'b01)}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] mag(logic s, logic [31:0] v);
        return (s && v[31]) ? (32'd0 - v) : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the
    // model across the rising edge. Inputs are changed by the caller afterwards.
    task automatic tick();
        logic exp_v, acc, pop;
        exp_t e;
        @(negedge clk);
        s_ready = req_ready_o; s_valid = resp_valid_o; s_busy = busy_o;
        s_data  = resp_data_o; s_tag   = resp_tag_o;
        exp_v = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        check("req_ready", s_ready, rst_ni && !flush_i && (exp_q.size() < DEPTH));
        check("resp_valid", s_valid, exp_v);
        check("busy", s_busy, exp_q.size() != 0);
        check("mul_x", mul_x_o, exp_x);
        check("mul_y", mul_y_o, exp_y);
        if (exp_v) begin
            check("resp_data", s_data, exp_q[0].data);
            check("resp_tag", s_tag, exp_q[0].tag);
        end
        acc = req_valid_i && s_ready;
        pop = s_valid && resp_ready_i;
        e.data  = ref_result(req_op_i, req_rs1_i, req_rs2_i);
        e.tag   = req_tag_i;
        e.avail = cyc + LAT + 1;
        @(posedge clk);
        #1;
        if (!rst_ni || flush_i) begin
            exp_q.delete();
            exp_x = '0;
            exp_y = '0;
        end else begin
            if (pop && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (acc) begin
                exp_q.push_back(e);
                accepts++;
            end
            exp_x = acc ? mag(req_op_i == 2'b01 || req_op_i == 2'b10, req_rs1_i) : 32'd0;
            exp_y = acc ? mag(req_op_i == 2'b01, req_rs2_i) : 32'd0;
        end
        cyc++;
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TW-1:0] t);
        req_valid_i = v; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_tag_i = t;
    endtask

    // Single isolated op: expects the response exactly LAT+1 cycles later.
    task automatic basic(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] t, input logic [31:0] want);
        set_req(1'b1, op, a, b, t);
        tick();
        check({name, "_accepted"}, s_ready, 1'b1);
        req_valid_i = 1'b0;
        repeat (LAT) tick();
        check({name, "_early"}, s_valid, 1'b0);
        tick();
        check({name, "_valid"}, s_valid, 1'b1);
        check({name, "_data"}, s_data, want);
        check({name, "_tag"}, s_tag, t);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; accepts = 0; pops = 0;
        exp_x = '0; exp_y = '0;
        rst_ni = 1'b0; flush_i = 1'b0; resp_ready_i = 1'b1;
        set_req(1'b0, 2'b00, 32'd0, 32'd0, '0);

        // Reset state
        repeat (2) tick();
        check("rst_data", s_data, 32'd0);
        check("rst_tag", s_tag, '0);
        rst_ni = 1'b1;
        tick();
        check("rst_release_ready", s_ready, 1'b1);

        // Basic ops, each alone
        basic("mul",    2'b00, 32'd7,        32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
        basic("mulhu",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        basic("mulh_m", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
        basic("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'd2,        5'd4, 32'hFFFF_FFFF);
        basic("mulh_n", 2'b01, 32'hFFFF_FFFF, 32'd1,        5'd5, 32'hFFFF_FFFF);

        // Back-to-back random ops
        accepts = 0; pops = 0;
        for (int i = 0; i < 20; i++) begin
            set_req(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, TW'(i));
            if (i % 5 == 0) req_rs1_i = 32'h8000_0000;
            tick();
            check("b2b_ready", s_ready, 1'b1);
        end
        req_valid_i = 1'b0;
        repeat (LAT + 2) tick();
        check("b2b_accepts", accepts, 20);
        check("b2b_pops", pops, 20);

        // Backpressure: stalled consumer caps accepts at DEPTH
        accepts = 0; pops = 0;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_req(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, TW'(i));
            tick();
        end
        check("bp_accepts", accepts, DEPTH);
        check("bp_ready_low", s_ready, 1'b0);
        req_valid_i = 1'b0;
        repeat (2) tick();
        // One pop, then refill the freed credit
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        set_req(1'b1, 2'b00, $urandom, $urandom, 5'd20);
        tick();
        check("bp_credit_back", s_ready, 1'b1);
        req_valid_i = 1'b0;
        repeat (LAT - 1) tick();
        // Push of the refilled op coincides with this pop: occupancy stays 7
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        repeat (2) tick();
        check("pp_ready", s_ready, 1'b1);
        check("pp_valid", s_valid, 1'b1);
        pops = 0;
        resp_ready_i = 1'b1;
        repeat (10) tick();
        check("pp_drain", pops, DEPTH - 1);
        check("pp_idle", s_busy, 1'b0);

        // Flush with 3 in flight and 2 queued
        resp_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_req(i < 2 || i > 3, 2'($urandom_range(0, 3)), $urandom, $urandom, TW'(i));
            tick();
        end
        check("fl_pre_valid", s_valid, 1'b1);
        set_req(1'b1, 2'b11, $urandom, $urandom, 5'd9);
        flush_i = 1'b1;
        tick();
        check("fl_no_accept", s_ready, 1'b0);
        flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b1;
        tick();
        check("fl_valid", s_valid, 1'b0);
        check("fl_busy", s_busy, 1'b0);
        pops = 0;
        repeat (10) tick();
        check("fl_no_stale", pops, 0);
        basic("fl_mul", 2'b00, 32'd3, 32'd4, 5'd7, 32'd12);

        // Reset mid-stream
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, TW'(i));
            tick();
        end
        rst_ni = 1'b0;
        repeat (2) tick();
        check("mr_data", s_data, 32'd0);
        check("mr_tag", s_tag, '0);
        check("mr_valid", s_valid, 1'b0);
        rst_ni = 1'b1; req_valid_i = 1'b0;
        pops = 0;
        tick();
        check("mr_ready", s_ready, 1'b1);
        repeat (8) tick();
        check("mr_no_resp", pops, 0);
        basic("mr_mulh", 2'b01, 32'hFFFF_FFF0, 32'd16, 5'd11, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
